// File: rtl/csa_seq_ctrl.sv
// Sequenced WIDTH-bit add/subtract built on one shared 8-bit carry-skip adder.
// Slices are processed LSB first with the inter-slice carry held in a register.

module jcarryskipadder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] p;
    logic [7:0] g;
    logic [4:0] rip_lo;
    logic [4:0] rip_hi;
    logic       c4;

    assign p = a ^ b;
    assign g = a & b;

    // Two 4-bit ripple blocks; a fully propagating block forwards its carry-in directly.
    always_comb begin
        rip_lo = '0;
        rip_hi = '0;
        rip_lo[0] = cin;
        for (int i = 0; i < 4; i++) begin
            rip_lo[i+1] = g[i] | (p[i] & rip_lo[i]);
        end
        c4 = (&p[3:0]) ? cin : rip_lo[4];
        rip_hi[0] = c4;
        for (int i = 0; i < 4; i++) begin
            rip_hi[i+1] = g[i+4] | (p[i+4] & rip_hi[i]);
        end
        cout = (&p[7:4]) ? c4 : rip_hi[4];
        sum  = p ^ {rip_hi[3:0], rip_lo[3:0]};
    end

endmodule

module csa_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carryin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             carryout,
    output logic             overflow
);

    localparam int unsigned SLICES = WIDTH / 8;
    localparam int unsigned CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);
    localparam int unsigned MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [CW+2:0]    base;
    logic [7:0]       slice_a;
    logic [7:0]       slice_b;
    logic [7:0]       slice_sum;
    logic             slice_cout;

    assign base    = {cnt_q, 3'b000};
    assign slice_a = opa_q[base +: 8];
    assign slice_b = opb_q[base +: 8];

    jcarryskipadder u_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Accumulator with the current slice merged in, so the last pass can register Y directly.
    always_comb begin
        acc_next = acc_q;
        acc_next[base +: 8] = slice_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Y         <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        opa_q    <= A;
                        opb_q    <= sub ? ~B : B;
                        carry_q  <= sub ? 1'b1 : carryin;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        in_ready <= 1'b0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    acc_q   <= acc_next;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        Y         <= acc_next;
                        carryout  <= slice_cout;
                        overflow  <= (opa_q[MSB] == opb_q[MSB]) && (acc_next[MSB] != opa_q[MSB]);
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Directed bench for csa_seq_ctrl (WIDTH=32) with hand-computed expected results.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_csa_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        carryin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Y;
    logic        carryout;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    csa_seq_ctrl #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .carryin   (carryin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .carryout  (carryout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an operation and return at the falling edge just after it was accepted.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                            input logic s, input string tag);
        int n;
        @(negedge clk);
        A        = a;
        B        = b;
        carryin  = ci;
        sub      = s;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept_wait"}, 32'(n < 20), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    endtask

    // Counts cycles from the accept edge until out_valid is seen.
    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
    endtask

    task automatic check_result(input string tag, input logic [31:0] ey, input logic eco,
                                input logic eov);
        check({tag, "_Y"}, Y, ey);
        check({tag, "_carryout"}, 32'(carryout), 32'(eco));
        check({tag, "_overflow"}, 32'(overflow), 32'(eov));
    endtask

    task automatic release_result(input string tag, input logic [31:0] ey);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_rise"}, 32'(in_ready), 32'd1);
        check({tag, "_Y_hold_idle"}, Y, ey);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                          input logic s, input logic [31:0] ey, input logic eco,
                          input logic eov, input string tag);
        start_op(a, b, ci, s, tag);
        wait_done(tag);
        check_result(tag, ey, eco, eov);
        release_result(tag, ey);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        carryin   = 1'b0;
        sub       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_Y", Y, 32'h0);
        check("rst_carryout", 32'(carryout), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "slice_carry");
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "propagate");
        run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf_add");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "ovf_sub");
        // carryin must be ignored when subtracting
        run_op(32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000D, 1'b1, 1'b0, "sub_ign_cin");

        // Backpressure: stall in DONE while the producer toggles in_valid.
        start_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, "bp");
        wait_done("bp");
        check_result("bp", 32'h0000_0030, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            A        = 32'hA5A5_0000 + 32'(i);
            B        = 32'h5A5A_FFFF;
            carryin  = 1'(i);
            sub      = 1'(i >> 1);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_Y", Y, 32'h0000_0030);
            check("bp_carryout", 32'(carryout), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        A         = 32'h0000_FFFF;
        B         = 32'h0000_0001;
        carryin   = 1'b0;
        sub       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_Y_hold", Y, 32'h0000_0030);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_pending_accepted", 32'(in_ready), 32'd0);
        wait_done("bp_pending");
        check_result("bp_pending", 32'h0001_0000, 1'b0, 1'b0);
        release_result("bp_pending", 32'h0001_0000);

        // Reset during the second RUN cycle aborts the operation.
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "mid_rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_Y", Y, 32'h0);
        check("mid_rst_carryout", 32'(carryout), 32'd0);
        repeat (6) @(negedge clk);
        check("mid_rst_no_result", 32'(out_valid), 32'd0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
